maxpool_reduce: RTL and testbench
=================================

Name: maxpool_reduce

Overview:
- Downstream consumer of the max-pooling address generator.
- Takes its per-cycle address stream (one address per window element, last element flagged), reads each pixel from the synchronous feature-map RAM, and reduces each window to its maximum.
- Writes one result per window into an output buffer with a ready/valid handshake.
- Drives the generator's enable through i_ready, so generator stalls propagate back-pressure.

Parameters:
- DW, 16, pixel/result data width
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- OUT_SIZE, 100, results per frame; output address wraps after OUT_SIZE-1
- FIFO_DEPTH, 4, output result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  address-stream element valid (generator o_valid)
- i_addr  in  16  feature-map read address (generator address)
- i_last  in  1  marks final element of current window
- i_ready  out  1  element accepted when i_valid && i_ready; feeds generator enable
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  16  RAM read address
- mem_rd_data  in  DW  RAM read data, valid exactly 1 cycle after mem_rd_en
- o_valid  out  1  result available
- o_data  out  DW  window maximum
- o_wr_addr  out  16  output-buffer index of o_data
- o_ready  in  1  result consumed when o_valid && o_ready
- frame_done  out  1  1-cycle pulse on handshake of result at index OUT_SIZE-1
- busy  out  1  any element in pipeline or FIFO non-empty

Behaviour:
- Reset (rst=0, async): all registers cleared. Outputs: i_ready=1, mem_rd_en=0, mem_rd_addr=0, o_valid=0, o_data=0, o_wr_addr=0, frame_done=0, busy=0. Reset mid-window discards the partial accumulator, in-flight reads and FIFO contents.
- Stage S1 (issue): on accept, the next cycle has mem_rd_en=1, mem_rd_addr=i_addr, and the last flag is registered alongside. No accept means mem_rd_en=0.
- Stage S2 (reduce): one cycle after mem_rd_en, mem_rd_data is compared.
  - first_elem flag: set at reset and after each last element.
  - If first_elem: acc = data. Else: acc = max(acc, data), compare signedness per SIGNED.
  - Ties keep acc; the value is unchanged either way.
- On S2 element with last=1: push max(acc, data) (or data if first_elem) into the FIFO, tagged with the current out_idx. out_idx increments, wrapping OUT_SIZE-1 -> 0. acc becomes don't-care and first_elem=1.
- Single-element window (i_last on the first element): result equals that pixel.
- Latency: from accept of the last element to o_valid = 3 cycles when the FIFO is empty (S1, S2, FIFO register).
- Throughput: 1 element per cycle sustained.
- Back-pressure: inflight = number of last-flagged elements in S1/S2.
  - i_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state only (no combinational path from o_ready).
  - The FIFO never overflows. Non-last elements do not consume credit.
  - A window whose last element is blocked simply waits. No element is dropped.
  - Upstream must hold i_addr/i_last stable while i_valid && !i_ready.
- Output: o_valid = FIFO non-empty. o_data/o_wr_addr show the head entry. Pop on o_valid && o_ready.
- Simultaneous push and pop: count unchanged, both take effect.
- Full FIFO with o_ready=0: the head is held stable indefinitely.
- frame_done pulses in the cycle after the handshake of the entry tagged OUT_SIZE-1.
- Arithmetic: o_wr_addr is 16 bits; the counter compare is against OUT_SIZE-1 exactly. No saturation on data, since max never exceeds the inputs.

Test Plan:
- Reset: rst=0 mid-stream with 2 results queued -> immediately o_valid=0, o_wr_addr=0, busy=0, i_ready=1. After release, the next window result is tagged 0.
- Unsigned 2x2 window: RAM[10..11,15..16] = 3,9,7,2, addresses 10,11,15,16 with i_last on 16, o_ready=1 -> o_data=9, o_wr_addr=0, o_valid exactly 3 cycles after the last accept.
- Signed: SIGNED=1, window values 0xFFFE, 0x8000, 0xFFFF -> o_data=0xFFFF. With SIGNED=0, same data -> o_data=0xFFFF. With values 0x0001, 0xFFFF, SIGNED=1 -> 0x0001.
- Single-element windows back-to-back for 5 cycles, i_last every element, values 4,1,8,8,0 -> results 4,1,8,8,0 at o_wr_addr 0..4, one per cycle.
- Back-pressure: o_ready=0, FIFO_DEPTH=4, stream of 1-element windows -> exactly 4 results queued, i_ready=0 thereafter, mem_rd_en stays 0. Raising o_ready drains in order, with no loss or duplication.
- Frame wrap: OUT_SIZE=100, 101 windows -> frame_done pulses once after index 99 is consumed. The 101st result has o_wr_addr=0.

Source files
------------

// File: rtl/maxpool_reduce.sv
// maxpool_reduce: reduces each address-generator window to its maximum pixel.
// Latency: 3 cycles from the last element's accept to o_valid when the FIFO is empty (S1, S2, FIFO).
// Backpressure: i_ready counts FIFO slots against last-flagged elements still in flight.
//   The count uses registered state only, so o_ready never feeds i_ready combinationally.
//
// Ports: clk/rst (async active-low); i_valid/i_addr/i_last/i_ready carry the address stream in;
//        mem_rd_en/mem_rd_addr/mem_rd_data form the synchronous RAM read port (1-cycle latency);
//        o_valid/o_data/o_wr_addr/o_ready carry results out; frame_done marks index OUT_SIZE-1 consumed;
//        busy is high while anything is in the pipeline or FIFO.

// Small synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module maxpool_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module maxpool_reduce #(
    parameter int DW         = 16,
    parameter int SIGNED     = 0,
    parameter int OUT_SIZE   = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [15:0]   i_addr,
    input  logic          i_last,
    output logic          i_ready,
    output logic          mem_rd_en,
    output logic [15:0]   mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [15:0]   o_wr_addr,
    input  logic          o_ready,
    output logic          frame_done,
    output logic          busy
);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_IDX = 16'(OUT_SIZE - 1);

    logic          accept;
    logic          s1_last;
    logic          s2_vld;
    logic          s2_last;
    logic          first_elem;
    logic [DW-1:0] acc;
    logic [DW-1:0] red_max;
    logic          data_gt;
    logic [15:0]   out_idx;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [1:0]    inflight;
    logic [CW:0]   credit_used;

    assign accept = i_valid && i_ready;

    // S1: issue the RAM read; the last flag travels with the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            s1_last     <= 1'b0;
        end else begin
            mem_rd_en <= accept;
            if (accept) begin
                mem_rd_addr <= i_addr;
                s1_last     <= i_last;
            end
        end
    end

    // S2 marker: read data is on mem_rd_data while s2_vld is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s2_vld  <= mem_rd_en;
            s2_last <= mem_rd_en & s1_last;
        end
    end

    // Strict greater-than: ties keep the accumulator.
    always_comb begin
        data_gt = 1'b0;
        if (SIGNED != 0) data_gt = $signed(mem_rd_data) > $signed(acc);
        else             data_gt = mem_rd_data > acc;
        red_max = (first_elem || data_gt) ? mem_rd_data : acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            first_elem <= 1'b1;
            out_idx    <= '0;
        end else if (s2_vld) begin
            acc        <= red_max;
            first_elem <= s2_last;
            if (s2_last) out_idx <= (out_idx == LAST_IDX) ? 16'd0 : out_idx + 16'd1;
        end
    end

    assign push = s2_vld & s2_last;
    assign pop  = o_valid & o_ready;

    maxpool_fifo #(
        .W     (16 + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({out_idx, red_max}),
        .pop      (pop),
        .head_dat ({o_wr_addr, o_data}),
        .count    (fifo_count)
    );

    assign o_valid = (fifo_count != '0);

    // Every last-flagged element in S1/S2 has a FIFO slot reserved for its result.
    assign inflight    = {1'b0, mem_rd_en & s1_last} + {1'b0, s2_last};
    assign credit_used = {1'b0, fifo_count} + {{(CW-1){1'b0}}, inflight};
    assign i_ready     = credit_used < (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_done <= 1'b0;
        else      frame_done <= pop && (o_wr_addr == LAST_IDX);
    end

    assign busy = mem_rd_en | s2_vld | o_valid;
endmodule

// File: tb/tb_maxpool_reduce.sv
module tb_maxpool_reduce;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_addr;
    logic        i_last;
    logic        o_ready;

    logic        i_ready_u, mem_rd_en_u, o_valid_u, frame_done_u, busy_u;
    logic [15:0] mem_rd_addr_u, o_data_u, o_wr_addr_u, rd_u;
    logic        i_ready_s, mem_rd_en_s, o_valid_s, frame_done_s, busy_s;
    logic [15:0] mem_rd_addr_s, o_data_s, o_wr_addr_s, rd_s;

    logic [15:0] ram [0:65535];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] win [$];
    logic [31:0] q_u [$];
    logic [31:0] q_s [$];
    logic [31:0] e_mon;
    int          tag_n = 0;
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    bit          p99_u = 0, p99_s = 0;
    logic [15:0] sv [5];

    always #5 clk = ~clk;

    maxpool_reduce #(.DW(16), .SIGNED(0), .OUT_SIZE(100), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_addr(i_addr), .i_last(i_last),
        .i_ready(i_ready_u), .mem_rd_en(mem_rd_en_u), .mem_rd_addr(mem_rd_addr_u),
        .mem_rd_data(rd_u), .o_valid(o_valid_u), .o_data(o_data_u), .o_wr_addr(o_wr_addr_u),
        .o_ready(o_ready), .frame_done(frame_done_u), .busy(busy_u));

    maxpool_reduce #(.DW(16), .SIGNED(1), .OUT_SIZE(100), .FIFO_DEPTH(4)) u_dut_s (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_addr(i_addr), .i_last(i_last),
        .i_ready(i_ready_s), .mem_rd_en(mem_rd_en_s), .mem_rd_addr(mem_rd_addr_s),
        .mem_rd_data(rd_s), .o_valid(o_valid_s), .o_data(o_data_s), .o_wr_addr(o_wr_addr_s),
        .o_ready(o_ready), .frame_done(frame_done_s), .busy(busy_s));

    // synchronous feature-map RAM, one read port per instance
    always @(posedge clk) begin
        if (mem_rd_en_u) rd_u <= ram[mem_rd_addr_u];
        if (mem_rd_en_s) rd_s <= ram[mem_rd_addr_s];
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // maximum of the current window, by plain integer comparison
    function automatic logic [15:0] wmax(input bit sgn);
        int          best;
        int          x;
        logic [15:0] bv;
        best = -100000;
        bv   = 16'h0;
        foreach (win[i]) begin
            if (sgn) x = int'($signed(win[i]));
            else     x = int'(win[i]);
            if (x > best) begin
                best = x;
                bv   = win[i];
            end
        end
        return bv;
    endfunction

    // monitor: records accepted elements, scores results and frame_done pulses
    always @(negedge clk) begin
        if (!rst) begin
            q_u.delete();
            q_s.delete();
            win.delete();
            tag_n = 0;
            p99_u = 0;
            p99_s = 0;
        end else begin
            if (frame_done_u || p99_u) chk("frame_done_u", {31'h0, frame_done_u}, {31'h0, p99_u});
            if (frame_done_s || p99_s) chk("frame_done_s", {31'h0, frame_done_s}, {31'h0, p99_s});
            if (frame_done_u) fd_cnt++;
            p99_u = 0;
            p99_s = 0;
            if (o_valid_u && o_ready) begin
                checks++;
                assert (q_u.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_result_u observed=%h expected=none", {o_wr_addr_u, o_data_u});
                end
                if (q_u.size() != 0) begin
                    e_mon = q_u.pop_front();
                    chk("result_u", {o_wr_addr_u, o_data_u}, e_mon);
                    p99_u = (e_mon[31:16] == 16'd99);
                end
            end
            if (o_valid_s && o_ready) begin
                checks++;
                assert (q_s.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_result_s observed=%h expected=none", {o_wr_addr_s, o_data_s});
                end
                if (q_s.size() != 0) begin
                    e_mon = q_s.pop_front();
                    chk("result_s", {o_wr_addr_s, o_data_s}, e_mon);
                    p99_s = (e_mon[31:16] == 16'd99);
                end
            end
            if (i_valid && i_ready_u) begin
                acc_cnt++;
                win.push_back(ram[i_addr]);
                if (i_last) begin
                    q_u.push_back({16'(tag_n), wmax(1'b0)});
                    q_s.push_back({16'(tag_n), wmax(1'b1)});
                    win.delete();
                    tag_n = (tag_n + 1) % 100;
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic last);
        int n;
        n       = 0;
        i_valid = 1'b1;
        i_addr  = a;
        i_last  = last;
        @(negedge clk);
        while (!i_ready_u && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=blocked expected=accept");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!o_valid_u && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_o_valid expected=o_valid", nm);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit done;
        rst = 1'b0; i_valid = 1'b0; i_addr = 16'h0; i_last = 1'b0; o_ready = 1'b1;
        ram[10] = 16'd3; ram[11] = 16'd9; ram[15] = 16'd7; ram[16] = 16'd2;
        ram[20] = 16'hFFFE; ram[21] = 16'h8000; ram[22] = 16'hFFFF;
        ram[23] = 16'h0001; ram[24] = 16'hFFFF;
        sv[0] = 16'd4; sv[1] = 16'd1; sv[2] = 16'd8; sv[3] = 16'd8; sv[4] = 16'd0;
        for (int i = 0; i < 5; i++) ram[30+i] = sv[i];
        for (int i = 40; i < 256; i++) ram[i] = 16'($urandom);

        // reset state
        #12;
        chk("rst_i_ready", {31'h0, i_ready_u}, 32'h1);
        chk("rst_mem_rd_en", {31'h0, mem_rd_en_u}, 32'h0);
        chk("rst_mem_rd_addr", {16'h0, mem_rd_addr_u}, 32'h0);
        chk("rst_o_valid", {31'h0, o_valid_u}, 32'h0);
        chk("rst_o_data", {16'h0, o_data_u}, 32'h0);
        chk("rst_o_wr_addr", {16'h0, o_wr_addr_u}, 32'h0);
        chk("rst_frame_done", {31'h0, frame_done_u}, 32'h0);
        chk("rst_busy", {31'h0, busy_u}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // unsigned 2x2 window with latency check
        send(16'd10, 1'b0); send(16'd11, 1'b0); send(16'd15, 1'b0); send(16'd16, 1'b1);
        chk("busy_inflight", {31'h0, busy_u}, 32'h1);
        @(negedge clk); chk("lat_c1_o_valid", {31'h0, o_valid_u}, 32'h0);
        @(negedge clk); chk("lat_c2_o_valid", {31'h0, o_valid_u}, 32'h0);
        @(negedge clk); chk("lat_c3_o_valid", {31'h0, o_valid_u}, 32'h1);
        chk("win2x2_data_u", {16'h0, o_data_u}, 32'd9);
        chk("win2x2_addr_u", {16'h0, o_wr_addr_u}, 32'd0);
        chk("win2x2_data_s", {16'h0, o_data_s}, 32'd9);
        idle(2);

        // signed vs unsigned compare
        send(16'd20, 1'b0); send(16'd21, 1'b0); send(16'd22, 1'b1);
        wait_valid("signed_a");
        chk("sgn_a_data_u", {16'h0, o_data_u}, 32'hFFFF);
        chk("sgn_a_data_s", {16'h0, o_data_s}, 32'hFFFF);
        idle(2);
        send(16'd23, 1'b0); send(16'd24, 1'b1);
        wait_valid("signed_b");
        chk("sgn_b_data_u", {16'h0, o_data_u}, 32'hFFFF);
        chk("sgn_b_data_s", {16'h0, o_data_s}, 32'h0001);
        idle(3);

        // back-to-back single-element windows, one result per cycle
        reset_pulse();
        fork
            begin
                for (int i = 0; i < 5; i++) send(16'(30 + i), 1'b1);
            end
            begin
                wait_valid("single");
                for (int i = 0; i < 5; i++) begin
                    chk("single_vld", {31'h0, o_valid_u}, 32'h1);
                    chk("single_data", {16'h0, o_data_u}, {16'h0, sv[i]});
                    chk("single_addr", {16'h0, o_wr_addr_u}, 32'(i));
                    @(negedge clk);
                end
            end
        join
        idle(4);

        // back-pressure: FIFO fills to exactly FIFO_DEPTH results
        o_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(16'(40 + i), 1'b1);
            end
            begin
                idle(12);
                chk("bp_accepted", 32'(acc_cnt), 32'd4);
                for (int i = 0; i < 4; i++) begin
                    chk("bp_i_ready", {31'h0, i_ready_u}, 32'h0);
                    chk("bp_mem_rd_en", {31'h0, mem_rd_en_u}, 32'h0);
                    chk("bp_head_hold", {16'h0, o_data_u}, {16'h0, ram[40]});
                    @(negedge clk);
                end
                @(posedge clk);
                #1 o_ready = 1'b1;
            end
        join
        idle(10);
        chk("bp_drained", 32'(q_u.size()), 32'd0);
        chk("bp_busy_idle", {31'h0, busy_u}, 32'h0);

        // reset with two results queued
        o_ready = 1'b0;
        send(16'd50, 1'b1); send(16'd51, 1'b1);
        idle(4);
        chk("mid_queued", {31'h0, o_valid_u}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_o_valid", {31'h0, o_valid_u}, 32'h0);
        chk("mid_rst_o_wr_addr", {16'h0, o_wr_addr_u}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy_u}, 32'h0);
        chk("mid_rst_i_ready", {31'h0, i_ready_u}, 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        o_ready = 1'b1;
        send(16'd52, 1'b1);
        wait_valid("after_reset");
        chk("after_rst_addr", {16'h0, o_wr_addr_u}, 32'h0);
        chk("after_rst_data", {16'h0, o_data_u}, {16'h0, ram[52]});
        idle(3);

        // randomized windows with random consumer stalls
        done = 0;
        fork
            begin
                for (int w = 0; w < 40; w++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int k = 0; k < len; k++)
                        send(16'($urandom_range(100, 199)), (k == len - 1));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 o_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        o_ready = 1'b1;
        idle(20);
        chk("rand_drained_u", 32'(q_u.size()), 32'd0);
        chk("rand_drained_s", 32'(q_s.size()), 32'd0);
        chk("rand_busy_idle", {31'h0, busy_u}, 32'h0);

        // frame wrap: 101 windows, one frame_done pulse, index wraps to 0
        reset_pulse();
        fd_cnt = 0;
        for (int i = 0; i < 101; i++) send(16'(200 + (i % 50)), 1'b1);
        idle(10);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_drained", 32'(q_u.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
